// File: rtl/image_crop_pkg.sv
// Shared VP definitions: default widths, decimation encoding and the skip mask helper.
package image_crop_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int X_W_DEF    = 12;
  localparam int Y_W_DEF    = 12;
  localparam int FCNT_W     = 16;

  typedef enum logic [1:0] {
    SKIP_1 = 2'd0,
    SKIP_2 = 2'd1,
    SKIP_4 = 2'd2,
    SKIP_8 = 2'd3
  } skip_e;

  // Low-bit mask of the window offset that must be zero for a kept sample.
  function automatic logic [2:0] skip_mask(input logic [1:0] s);
    case (skip_e'(s))
      SKIP_1:  skip_mask = 3'b000;
      SKIP_2:  skip_mask = 3'b001;
      SKIP_4:  skip_mask = 3'b011;
      default: skip_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/vp_timing_counter.sv
// Frame-start / line-end detection, per-pixel x/y coordinates and self-measured geometry.
module vp_timing_counter
  import image_crop_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs,
  input  logic              de,
  output logic              fs,
  output logic [X_W-1:0]    px,
  output logic [Y_W-1:0]    py,
  output logic [X_W-1:0]    meas_h,
  output logic [Y_W-1:0]    meas_v,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic           vs_d, de_d, de_fall;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;

  assign fs      = vs & ~vs_d;
  assign de_fall = de_d & ~de;

  // The frame-start pixel is always (0,0), even if the counters hold stale values.
  assign px = fs ? '0 : x_cnt;
  assign py = fs ? '0 : y_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      meas_h    <= '0;
      meas_v    <= '0;
      frame_cnt <= '0;
    end else begin
      vs_d <= vs;
      de_d <= de;
      if (de_fall)
        meas_h <= x_cnt;
      if (fs) begin
        // A line still open at frame start counts toward the finished frame.
        meas_v    <= (x_cnt != '0 && y_cnt != '1) ? y_cnt + 1'b1 : y_cnt;
        y_cnt     <= '0;
        x_cnt     <= {{(X_W-1){1'b0}}, de};
        frame_cnt <= frame_cnt + 1'b1;
      end else if (de) begin
        if (x_cnt != '1)
          x_cnt <= x_cnt + 1'b1;
      end else if (de_fall) begin
        x_cnt <= '0;
        if (y_cnt != '1)
          y_cnt <= y_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_crop.sv
// Crop/decimate stage: frame-synchronous shadow window, registered keep decision, 2-cycle output pipe.
module image_crop
  import image_crop_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [X_W-1:0]    start_x,
  input  logic [Y_W-1:0]    start_y,
  input  logic [X_W-1:0]    end_x,
  input  logic [Y_W-1:0]    end_y,
  input  logic [1:0]        skip_x,
  input  logic [1:0]        skip_y,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic [X_W-1:0]    meas_h,
  output logic [Y_W-1:0]    meas_v,
  output logic              cfg_err,
  output logic [15:0]       frame_cnt
);

  logic           fs;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;

  vp_timing_counter #(.X_W(X_W), .Y_W(Y_W)) u_tc (
    .clk       (clk),
    .rst       (rst),
    .vs        (vs_i),
    .de        (de_i),
    .fs        (fs),
    .px        (px),
    .py        (py),
    .meas_h    (meas_h),
    .meas_v    (meas_v),
    .frame_cnt (frame_cnt)
  );

  logic           sh_en;
  logic [X_W-1:0] sh_sx, sh_ex;
  logic [Y_W-1:0] sh_sy, sh_ey;
  logic [1:0]     sh_skx, sh_sky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en   <= 1'b0;
      sh_sx   <= '0;
      sh_sy   <= '0;
      sh_ex   <= '1;
      sh_ey   <= '1;
      sh_skx  <= '0;
      sh_sky  <= '0;
      cfg_err <= 1'b0;
    end else if (fs) begin
      sh_en   <= en;
      sh_sx   <= start_x;
      sh_sy   <= start_y;
      sh_ex   <= end_x;
      sh_ey   <= end_y;
      sh_skx  <= skip_x;
      sh_sky  <= skip_y;
      cfg_err <= en && (start_x >= end_x || start_y >= end_y);
    end
  end

  // The frame-start pixel must see the window it is about to latch, not the old one.
  logic [X_W-1:0] c_sx, c_ex;
  logic [Y_W-1:0] c_sy, c_ey;
  logic [1:0]     c_skx, c_sky;
  logic [2:0]     dx_lo, dy_lo;
  logic           in_win, keep;

  assign c_sx  = fs ? start_x : sh_sx;
  assign c_ex  = fs ? end_x   : sh_ex;
  assign c_sy  = fs ? start_y : sh_sy;
  assign c_ey  = fs ? end_y   : sh_ey;
  assign c_skx = fs ? skip_x  : sh_skx;
  assign c_sky = fs ? skip_y  : sh_sky;

  // Only the low bits of the window offset matter for the decimation phase.
  assign dx_lo  = px[2:0] - c_sx[2:0];
  assign dy_lo  = py[2:0] - c_sy[2:0];
  assign in_win = (px >= c_sx) && (px < c_ex) && (py >= c_sy) && (py < c_ey);
  assign keep   = in_win && ((dx_lo & skip_mask(c_skx)) == 3'b000)
                         && ((dy_lo & skip_mask(c_sky)) == 3'b000);

  logic              s1_vs, s1_hs, s1_de, s1_keep;
  logic [DATA_W-1:0] s1_data;
  logic              de_nxt;

  assign de_nxt = sh_en ? (s1_de & s1_keep & ~cfg_err) : s1_de;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_keep <= 1'b0;
      s1_data <= '0;
      vs_o    <= 1'b0;
      hs_o    <= 1'b0;
      de_o    <= 1'b0;
      data_o  <= '0;
    end else begin
      s1_vs   <= vs_i;
      s1_hs   <= hs_i;
      s1_de   <= de_i;
      s1_keep <= keep;
      s1_data <= data_i;
      vs_o    <= s1_vs;
      hs_o    <= s1_hs;
      de_o    <= de_nxt;
      data_o  <= de_nxt ? s1_data : '0;
    end
  end

endmodule

// File: tb/tb_image_crop.sv
// Directed bench for image_crop: bypass, crop, decimation, shadowing, invalid window and mid-frame reset.
module tb_image_crop;

  localparam int DW = 24;
  localparam int XW = 12;
  localparam int YW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [XW-1:0] start_x, end_x;
  logic [YW-1:0] start_y, end_y;
  logic [1:0]    skip_x, skip_y;
  logic          vs_i, hs_i, de_i;
  logic [DW-1:0] data_i;
  logic          vs_o, hs_o, de_o, cfg_err;
  logic [DW-1:0] data_o;
  logic [XW-1:0] meas_h;
  logic [YW-1:0] meas_v;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  image_crop #(.DATA_W(DW), .X_W(XW), .Y_W(YW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .skip_x(skip_x), .skip_y(skip_y),
    .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
    .meas_h(meas_h), .meas_v(meas_v), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Output monitor: kept pixels, per-pixel latency, zero-data rule and exact 2-cycle delay.
  int          cyc = 0;
  logic        mon_chk = 1'b0;
  int          de_cnt, lat_err, zero_err, dly_err;
  logic [15:0] kept[$];
  int          cyc_of[int];
  logic [DW+2:0] h1, h2;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (de_o) begin
        de_cnt++;
        kept.push_back(data_o[15:0]);
        if (!cyc_of.exists(int'(data_o[15:0])) || (cyc - cyc_of[int'(data_o[15:0])]) != 2)
          lat_err++;
      end else if (data_o !== '0) begin
        zero_err++;
      end
      if (mon_chk && ({vs_o, hs_o, de_o, data_o} !== h2))
        dly_err++;
      h2 = h1;
      h1 = {vs_i, hs_i, de_i, data_i};
      if (de_i)
        cyc_of[int'(data_i[15:0])] = cyc;
    end
  end

  task automatic mon_clear();
    de_cnt = 0; lat_err = 0; zero_err = 0; dly_err = 0;
    kept.delete();
    h1 = '0; h2 = '0;
  endtask

  task automatic cyc_drv(input logic v, input logic h, input logic d, input logic [DW-1:0] dat);
    vs_i = v; hs_i = h; de_i = d; data_i = dat;
    @(posedge clk); #1;
  endtask

  task automatic drive_vs();
    cyc_drv(1'b1, 1'b0, 1'b0, '0);
    cyc_drv(1'b1, 1'b0, 1'b0, '0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drive_line(input int y, input int w);
    for (int x = 0; x < w; x++)
      cyc_drv(1'b0, 1'b0, 1'b1, {8'h5A, 8'(y), 8'(x)});
    for (int b = 0; b < 4; b++)
      cyc_drv(1'b0, b < 2, 1'b0, '0);
  endtask

  task automatic drive_frame(input int w, input int h, input int chg_line, input logic [XW-1:0] chg_sx);
    drive_vs();
    for (int y = 0; y < h; y++) begin
      if (y == chg_line) start_x = chg_sx;
      drive_line(y, w);
    end
  endtask

  task automatic set_win(input int sx, input int sy, input int ex, input int ey, input int kx, input int ky);
    start_x = XW'(sx); start_y = YW'(sy); end_x = XW'(ex); end_y = YW'(ey);
    skip_x = 2'(kx); skip_y = 2'(ky);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: outputs %h, expected all zero",
               {vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if ({vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: outputs %h, expected all zero",
               {vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt});
    end
  endtask

  task automatic test_bypass();
    en = 1'b0;
    set_win(4, 2, 8, 5, 0, 0);
    mon_clear();
    mon_chk = 1'b1;
    drive_frame(16, 8, -1, '0);
    drive_vs();
    mon_chk = 1'b0;
    n_cmp++; if (dly_err !== 0) begin n_bad++; $display("FAIL bypass_delay: %0d cycles differ, expected 0", dly_err); end
    n_cmp++; if (de_cnt !== 128) begin n_bad++; $display("FAIL bypass_count: got %0d expected 128", de_cnt); end
    n_cmp++; if (meas_h !== 12'd16) begin n_bad++; $display("FAIL meas_h: got %0d expected 16", meas_h); end
    n_cmp++; if (meas_v !== 12'd8) begin n_bad++; $display("FAIL meas_v: got %0d expected 8", meas_v); end
    n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL bypass_frame_cnt: got %0d expected 2", frame_cnt); end
    n_cmp++; if (zero_err !== 0) begin n_bad++; $display("FAIL bypass_zero_data: %0d cycles, expected 0", zero_err); end
  endtask

  task automatic test_window();
    int idx, bad;
    en = 1'b1;
    set_win(4, 2, 8, 5, 0, 0);
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (de_cnt !== 12) begin n_bad++; $display("FAIL window_count: got %0d expected 12", de_cnt); end
    idx = 0; bad = 0;
    for (int y = 2; y < 5; y++)
      for (int x = 4; x < 8; x++) begin
        if (idx >= kept.size() || kept[idx] !== {8'(y), 8'(x)}) bad++;
        idx++;
      end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL window_pixels: %0d wrong, expected 0", bad); end
    n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL window_latency: %0d pixels not at 2 cycles, expected 0", lat_err); end
    n_cmp++; if (zero_err !== 0) begin n_bad++; $display("FAIL window_zero_data: %0d cycles, expected 0", zero_err); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL window_cfg_err: got %0b expected 0", cfg_err); end
  endtask

  task automatic test_skip();
    int idx, bad;
    set_win(0, 0, 16, 8, 1, 2);
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (de_cnt !== 16) begin n_bad++; $display("FAIL skip_count: got %0d expected 16", de_cnt); end
    idx = 0; bad = 0;
    for (int y = 0; y < 8; y += 4)
      for (int x = 0; x < 16; x += 2) begin
        if (idx >= kept.size() || kept[idx] !== {8'(y), 8'(x)}) bad++;
        idx++;
      end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL skip_pixels: %0d wrong, expected 0", bad); end
  endtask

  task automatic test_mid_change();
    int idx, bad;
    set_win(4, 2, 8, 5, 0, 0);
    mon_clear();
    drive_frame(16, 8, 1, 12'd0);
    n_cmp++; if (de_cnt !== 12) begin n_bad++; $display("FAIL shadow_hold_count: got %0d expected 12", de_cnt); end
    n_cmp++; if (kept.size() == 0 || kept[0] !== 16'h0204) begin
      n_bad++; $display("FAIL shadow_hold_first: got %h expected 0204", kept.size() ? kept[0] : 16'hxxxx);
    end
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (de_cnt !== 24) begin n_bad++; $display("FAIL shadow_apply_count: got %0d expected 24", de_cnt); end
    idx = 0; bad = 0;
    for (int y = 2; y < 5; y++)
      for (int x = 0; x < 8; x++) begin
        if (idx >= kept.size() || kept[idx] !== {8'(y), 8'(x)}) bad++;
        idx++;
      end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL shadow_apply_pixels: %0d wrong, expected 0", bad); end
  endtask

  task automatic test_cfg_err();
    set_win(10, 2, 10, 5, 0, 0);
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_set: got %0b expected 1", cfg_err); end
    n_cmp++; if (de_cnt !== 0) begin n_bad++; $display("FAIL cfg_err_count: got %0d expected 0", de_cnt); end
    set_win(4, 2, 8, 5, 0, 0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_hold: got %0b expected 1", cfg_err); end
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clear: got %0b expected 0", cfg_err); end
    n_cmp++; if (de_cnt !== 12) begin n_bad++; $display("FAIL cfg_err_recover_count: got %0d expected 12", de_cnt); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    set_win(4, 2, 8, 5, 0, 0);
    drive_vs();
    for (int y = 0; y < 3; y++) drive_line(y, 16);
    for (int x = 0; x < 6; x++) cyc_drv(1'b0, 1'b0, 1'b1, {8'h5A, 8'd3, 8'(x)});
    vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = '0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_flush: outputs %h, expected all zero",
               {vs_o, hs_o, de_o, data_o, meas_h, meas_v, cfg_err, frame_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    cyc_drv(1'b0, 1'b0, 1'b0, '0);
    mon_clear();
    mon_chk = 1'b1;
    for (int y = 4; y < 8; y++) drive_line(y, 16);
    mon_chk = 1'b0;
    n_cmp++; if (de_cnt !== 64) begin n_bad++; $display("FAIL reset_bypass_count: got %0d expected 64", de_cnt); end
    n_cmp++; if (dly_err !== 0) begin n_bad++; $display("FAIL reset_bypass_delay: %0d cycles differ, expected 0", dly_err); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt0: got %0d expected 0", frame_cnt); end
    mon_clear();
    drive_frame(16, 8, -1, '0);
    n_cmp++; if (de_cnt !== 12) begin n_bad++; $display("FAIL reset_crop_count: got %0d expected 12", de_cnt); end
    n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL reset_crop_latency: %0d pixels off, expected 0", lat_err); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL reset_frame_cnt1: got %0d expected 1", frame_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    set_win(0, 0, 0, 0, 0, 0);
    vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = '0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_window();
    test_skip();
    test_mid_change();
    test_cfg_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
